// File: rtl/fpu_normalize_round.sv
// Final normalize/round/pack stage of the binary32 adder: 2-stage valid/ready pipeline.
// Optional exception flags {overflow, underflow, inexact} exist only when FPU_NR_FLAGS_EN is defined.
module fpu_normalize_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_mant,
    input  logic        in_sticky,
    input  logic        in_bypass,
    input  logic [31:0] in_bypass_data,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FPU_NR_FLAGS_EN
    output logic [2:0]  out_flags,
`endif
    output logic [31:0] out_data
);

    logic               w_s1_load;
    logic               w_s2_load;
    logic [4:0]         w_lz;
    logic [25:0]        w_shl;
    logic [25:0]        w_n_mant;
    logic signed [9:0]  w_n_exp;
    logic               w_n_sticky;
    logic               w_n_zero;
    logic               w_n_flush;

    logic               r_s1_valid;
    logic               r_s1_bypass;
    logic [31:0]        r_s1_bdata;
    logic               r_s1_sign;
    logic signed [9:0]  r_s1_exp;
    logic [25:0]        r_s1_mant;
    logic               r_s1_sticky;
    logic               r_s1_zero;
    logic               r_s1_flush;

    logic               w_incr;
    logic [24:0]        w_sum;
    logic signed [9:0]  w_r_exp;
    logic [22:0]        w_frac;
    logic               w_ovf;
    logic [31:0]        w_pack;

    logic               r_out_valid;
    logic [31:0]        r_out_data;

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Leading-zero count of the non-carry mantissa; 26 when it is all zero
    always_comb begin
        w_lz = 5'd26;
        for (int i = 0; i < 26; i++) begin
            if (in_mant[i]) begin
                w_lz = 5'd25 - 5'(i);
            end else begin
                w_lz = w_lz;
            end
        end
        w_shl = in_mant[25:0] << w_lz;
    end

    // Stage-1 normalize: carry right-shift, exact zero, or left-shift with flush detection
    always_comb begin
        w_n_mant   = 26'd0;
        w_n_exp    = 10'sd0;
        w_n_sticky = in_sticky;
        w_n_zero   = 1'b0;
        w_n_flush  = 1'b0;
        if (in_mant[26]) begin
            w_n_mant   = in_mant[26:1];
            w_n_sticky = in_sticky | in_mant[0];
            w_n_exp    = $signed({2'b00, in_exp}) + 10'sd1;
        end else if ((in_mant == 27'd0) && !in_sticky) begin
            w_n_zero   = 1'b1;
        end else begin
            w_n_mant   = w_shl;
            w_n_exp    = $signed({2'b00, in_exp}) - $signed({5'd0, w_lz});
            w_n_flush  = (in_exp <= {3'b000, w_lz});
        end
    end

    // Stage-1 pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_bypass <= 1'b0;
            r_s1_bdata  <= 32'd0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= 10'sd0;
            r_s1_mant   <= 26'd0;
            r_s1_sticky <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_flush  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid  <= in_valid;
            r_s1_bypass <= in_bypass;
            r_s1_bdata  <= in_bypass_data;
            r_s1_sign   <= in_sign;
            r_s1_exp    <= w_n_exp;
            r_s1_mant   <= w_n_mant;
            r_s1_sticky <= w_n_sticky;
            r_s1_zero   <= w_n_zero;
            r_s1_flush  <= w_n_flush;
        end
    end

    // Round-to-nearest-even on the 24-bit significand; a carry out renormalizes to 1.0
    assign w_incr  = r_s1_mant[1] & (r_s1_mant[0] | r_s1_sticky | r_s1_mant[2]);
    assign w_sum   = {1'b0, r_s1_mant[25:2]} + {24'd0, w_incr};
    assign w_r_exp = w_sum[24] ? (r_s1_exp + 10'sd1) : r_s1_exp;
    assign w_frac  = w_sum[24] ? 23'd0 : w_sum[22:0];
    assign w_ovf   = (r_s1_exp >= 10'sd255) || (w_r_exp >= 10'sd255);

    // Stage-2 result selection
    always_comb begin
        w_pack = 32'd0;
        if (r_s1_bypass) begin
            w_pack = r_s1_bdata;
        end else if (r_s1_zero) begin
            w_pack = 32'd0;
        end else if (r_s1_flush) begin
            w_pack = {r_s1_sign, 31'd0};
        end else if (w_ovf) begin
            w_pack = {r_s1_sign, 8'hFF, 23'd0};
        end else begin
            w_pack = {r_s1_sign, w_r_exp[7:0], w_frac};
        end
    end

    // Output register; holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            r_out_data  <= r_s1_valid ? w_pack : r_out_data;
        end
    end

`ifdef FPU_NR_FLAGS_EN
    logic       w_inexact;
    logic [2:0] w_flags;
    logic [2:0] r_out_flags;

    assign w_inexact = r_s1_mant[1] | r_s1_mant[0] | r_s1_sticky;
    assign out_flags = r_out_flags;

    // Flag selection mirrors the result priority above
    always_comb begin
        w_flags = 3'b000;
        if (r_s1_bypass || r_s1_zero) begin
            w_flags = 3'b000;
        end else if (r_s1_flush) begin
            w_flags = {1'b0, 1'b1, w_inexact};
        end else if (w_ovf) begin
            w_flags = 3'b101;
        end else begin
            w_flags = {1'b0, 1'b0, w_inexact};
        end
    end

    // Flags registered alongside out_data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_flags <= 3'b000;
        end else if (w_s2_load && r_s1_valid) begin
            r_out_flags <= w_flags;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Scoreboard bench for fpu_normalize_round: directed corner cases, backpressure/reset, random traffic.
module tb_fpu_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_sticky;
    logic        in_bypass;
    logic [31:0] in_bypass_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef FPU_NR_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [34:0] sb_q[$];
    bit          rand_ready  = 1'b0;
    bit          force_ready = 1'b1;

    always #5 clk = ~clk;

    fpu_normalize_round dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .in_sticky      (in_sticky),
        .in_bypass      (in_bypass),
        .in_bypass_data (in_bypass_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef FPU_NR_FLAGS_EN
        .out_flags      (out_flags),
`endif
        .out_data       (out_data)
    );

    // Reference: value-level rounding via integer remainder vs. half-ulp; returns {flags, word}
    function automatic logic [34:0] ref_model(input logic byp, input logic [31:0] bd, input logic s,
                                              input logic [7:0] ex, input logic [26:0] m, input logic st);
        int          p;
        int          sh;
        int          e;
        logic [63:0] kept;
        logic [63:0] rem;
        logic [63:0] half;
        logic        inex;
        logic        up;
        logic [7:0]  e8;
        if (byp) return {3'b000, bd};
        if ((m == 27'd0) && !st) return 35'd0;
        p = -1;
        for (int i = 0; i < 27; i++) if (m[i]) p = i;
        sh = p - 23;
        e  = int'(ex) + p - 25;
        if (sh > 0) begin
            kept = {37'd0, m} >> sh;
            rem  = {37'd0, m} & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
        end else begin
            kept = {37'd0, m} << (-sh);
            rem  = 64'd0;
            half = 64'd1;
        end
        inex = (rem != 64'd0) || st;
        up   = (rem > half) || ((rem == half) && (st || kept[0]));
        if (e <= 0) return {1'b0, 1'b1, inex, s, 31'd0};
        if (up) kept = kept + 64'd1;
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {3'b101, s, 8'hFF, 23'd0};
        e8 = e[7:0];
        return {1'b0, 1'b0, inex, s, e8, kept[22:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Present one item and hold it until accepted; queue its expected result at the accept point
    task automatic send(input logic byp, input logic [31:0] bd, input logic s, input logic [7:0] ex,
                        input logic [26:0] m, input logic st, input logic [34:0] expv, input bit use_model);
        int budget;
        @(posedge clk); #1;
        in_valid = 1'b1; in_bypass = byp; in_bypass_data = bd;
        in_sign = s; in_exp = ex; in_mant = m; in_sticky = st;
        budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (in_ready) begin
            sb_q.push_back(use_model ? ref_model(byp, bd, s, ex, m, st) : expv);
        end else begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready=0, required 1");
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d items outstanding, required 0", sb_q.size());
        end
    endtask

    // Downstream ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    // Monitor: pop and compare on every output transfer, and check stability while stalled
    initial begin
        logic [34:0] e;
        logic        prev_stall;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("hold_stable", {out_valid, out_data}, {1'b1, prev_data});
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_output: got %0h, expected no output", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_data", out_data, e[31:0]);
`ifdef FPU_NR_FLAGS_EN
                        check("out_flags", out_flags, e[34:32]);
`endif
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        logic        r_byp;
        logic [31:0] r_bd;
        logic        r_s;
        logic [7:0]  r_ex;
        logic [26:0] r_m;
        logic [26:0] r_mask;
        logic        r_st;
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 27'd0;
        in_sticky = 1'b0; in_bypass = 1'b0; in_bypass_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef FPU_NR_FLAGS_EN
        check("rst_out_flags", out_flags, 3'b000);
`endif

        // 1.0 + 1.0 with latency check
        send(1'b0, 32'd0, 1'b0, 8'd127, 27'h4000000, 1'b0, {3'b000, 32'h4000_0000}, 1'b0);
        idle();
        @(negedge clk);
        check("latency_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check("latency_cycle2", out_valid, 1'b1);

        send(1'b0, 32'd0, 1'b0, 8'd127, 27'h0000004, 1'b0, {3'b000, 32'h3400_0000}, 1'b0);
        send(1'b0, 32'd0, 1'b0, 8'd127, 27'h2000002, 1'b0, {3'b001, 32'h3F80_0000}, 1'b0);
        send(1'b0, 32'd0, 1'b0, 8'd127, 27'h2000006, 1'b0, {3'b001, 32'h3F80_0002}, 1'b0);
        send(1'b0, 32'd0, 1'b0, 8'd254, 27'h4000000, 1'b0, {3'b101, 32'h7F80_0000}, 1'b0);
        send(1'b0, 32'd0, 1'b1, 8'd100, 27'h0000000, 1'b0, {3'b000, 32'h0000_0000}, 1'b0);
        send(1'b0, 32'd0, 1'b1, 8'd3,   27'h0000004, 1'b0, {3'b010, 32'h8000_0000}, 1'b0);
        send(1'b0, 32'd0, 1'b0, 8'd23,  27'h0000004, 1'b0, {3'b010, 32'h0000_0000}, 1'b0);
        send(1'b0, 32'd0, 1'b0, 8'd24,  27'h0000004, 1'b0, {3'b000, 32'h0080_0000}, 1'b0);
        send(1'b0, 32'd0, 1'b0, 8'd127, 27'h3FFFFFE, 1'b0, {3'b001, 32'h4000_0000}, 1'b0);
        send(1'b0, 32'd0, 1'b0, 8'd254, 27'h3FFFFFE, 1'b0, {3'b101, 32'h7F80_0000}, 1'b0);
        send(1'b1, 32'hFF80_0000, 1'b0, 8'd0, 27'd0, 1'b0, {3'b000, 32'hFF80_0000}, 1'b0);
        idle();
        drain();

        // Backpressure: two accepted, third refused, then drain in order
        force_ready = 1'b0;
        idle();
        send(1'b0, 32'd0, 1'b0, 8'd127, 27'h4000000, 1'b0, {3'b000, 32'h4000_0000}, 1'b0);
        send(1'b1, 32'h7FC0_0000, 1'b0, 8'd0, 27'd0, 1'b0, {3'b000, 32'h7FC0_0000}, 1'b0);
        @(posedge clk); #1;
        in_bypass = 1'b0; in_sign = 1'b1; in_exp = 8'd127; in_mant = 27'h2000000; in_sticky = 1'b0;
        @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        force_ready = 1'b1;
        send(1'b0, 32'd0, 1'b1, 8'd127, 27'h2000000, 1'b0, {3'b000, 32'hBF80_0000}, 1'b0);
        idle();
        drain();

        // Reset while stalled discards in-flight items
        force_ready = 1'b0;
        idle();
        send(1'b0, 32'd0, 1'b0, 8'd127, 27'h4000000, 1'b0, 35'd0, 1'b1);
        send(1'b0, 32'd0, 1'b0, 8'd130, 27'h2000000, 1'b0, 35'd0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; sb_q.delete(); force_ready = 1'b1;
        @(negedge clk);
        check("rst_stall_out_valid", out_valid, 1'b0);
        check("rst_stall_in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_no_ghost", out_valid, 1'b0);

        // Random traffic with random downstream stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) idle();
            r_byp = ($urandom_range(0, 9) == 0);
            r_bd  = $urandom;
            r_s   = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       r_ex = 8'($urandom_range(0, 26));
                1:       r_ex = 8'($urandom_range(250, 255));
                default: r_ex = 8'($urandom);
            endcase
            r_mask = (27'd1 << $urandom_range(0, 27)) - 27'd1;
            r_m    = 27'($urandom) & r_mask;
            if ($urandom_range(0, 3) == 0) r_m[26] = 1'b1;
            r_st   = (r_m == 27'd0) ? 1'b0 : 1'($urandom);
            send(r_byp, r_bd, r_s, r_ex, r_m, r_st, 35'd0, 1'b1);
        end
        idle();
        rand_ready = 1'b0;
        force_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
